// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NUM_RD registered read ports, two write
// ports (port 1 wins collisions), optional same-edge bypass, hardwired zero register.

module regfile_mp_rdport #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] storedVal,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] data
);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] nextVal;

  always_comb begin
    nextVal = storedVal;
    if (BYPASS != 0) begin
      if (we0 && waddr0 == addr) nextVal = wdata0;
      if (we1 && waddr1 == addr) nextVal = wdata1;
    end
    // Zero register masks everything, including a bypassed write to it.
    if (addr == ZERO_A) nextVal = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   data <= '0;
    else if (en) data <= nextVal;
  end
endmodule

module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  generate
    if (NUM_RD < 1 || NUM_RD > 4 || ZERO_REG < 0 || ZERO_REG >= DEPTH) begin : g_badParam
      $error("regfile_mp: NUM_RD must be 1..4 and ZERO_REG below 2**ADDR_W");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  // Port 1 is written second so it overrides port 0 on an address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (we0 && waddr0 != ZERO_A) mem[waddr0] <= wdata0;
      if (we1 && waddr1 != ZERO_A) mem[waddr1] <= wdata1;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_mp_rdport #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
      ) u_rd (
        .clk      (clk),
        .reset    (reset),
        .en       (rd_en[i]),
        .addr     (rd_addr[i*ADDR_W +: ADDR_W]),
        .storedVal(mem[rd_addr[i*ADDR_W +: ADDR_W]]),
        .we0      (we0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .we1      (we1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .data     (rd_data[i*DATA_W +: DATA_W])
      );
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: BYPASS=1 and BYPASS=0 instances share stimulus and are
// compared against an array-based model of the register file.

module tb_regfile_mp;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int ZR = 31;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NR-1:0]  rdEn = '0;
  logic [NR*AW-1:0] rdAddr = '0;
  logic [NR*DW-1:0] rdData1, rdData0;
  logic           we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0]  waddr0 = '0, waddr1 = '0;
  logic [DW-1:0]  wdata0 = '0, wdata1 = '0;

  int total = 0;
  int passed = 0;

  logic [DW-1:0] model [32];
  logic [DW-1:0] exp1 [NR];
  logic [DW-1:0] exp0 [NR];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(ZR), .BYPASS(1)) dutByp (
    .clk(clk), .reset(reset), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData1),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(ZR), .BYPASS(0)) dutNoByp (
    .clk(clk), .reset(reset), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData0),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1));

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, want);
  endtask

  task automatic checkAll(input string tag);
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("%s byp p%0d", tag, p), rdData1[p*DW +: DW], exp1[p]);
      chk($sformatf("%s nobyp p%0d", tag, p), rdData0[p*DW +: DW], exp0[p]);
    end
  endtask

  task automatic idle();
    rdEn = '0; we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic setRd(input int p, input logic en, input int a);
    rdEn[p] = en;
    rdAddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic setW0(input logic en, input int a, input logic [DW-1:0] d);
    we0 = en; waddr0 = AW'(a); wdata0 = d;
  endtask

  task automatic setW1(input logic en, input int a, input logic [DW-1:0] d);
    we1 = en; waddr1 = AW'(a); wdata1 = d;
  endtask

  // Model one rising edge from the current inputs, then check both instances.
  task automatic doCycle(input string tag);
    int a;
    logic [DW-1:0] old, fwd;
    for (int p = 0; p < NR; p++) begin
      if (rdEn[p]) begin
        a = int'(rdAddr[p*AW +: AW]);
        old = model[a];
        fwd = old;
        if (we1 && int'(waddr1) == a) fwd = wdata1;
        else if (we0 && int'(waddr0) == a) fwd = wdata0;
        exp1[p] = (a == ZR) ? '0 : fwd;
        exp0[p] = (a == ZR) ? '0 : old;
      end
    end
    if (we0 && int'(waddr0) != ZR) model[waddr0] = wdata0;
    if (we1 && int'(waddr1) != ZR) model[waddr1] = wdata1;
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) model[k] = '0;
    for (int p = 0; p < NR; p++) begin exp1[p] = '0; exp0[p] = '0; end

    // Reset state
    #1;
    checkAll("reset_init");
    @(posedge clk); @(negedge clk);
    reset = 1'b0;

    // Async reset clears outputs and storage mid-cycle
    setW0(1, 3, 64'hDEAD); doCycle("wr3"); idle();
    setRd(0, 1, 3); setRd(1, 1, 3); doCycle("rd3_dead"); idle();
    #3 reset = 1'b1;
    #1;
    for (int k = 0; k < 32; k++) model[k] = '0;
    for (int p = 0; p < NR; p++) begin exp1[p] = '0; exp0[p] = '0; end
    checkAll("async_reset");
    setW0(1, 3, 64'hBEEF); setRd(0, 1, 3); setRd(1, 1, 3);
    @(posedge clk); #1;
    checkAll("reset_blocks");
    idle();
    @(negedge clk) reset = 1'b0;
    setRd(0, 1, 3); setRd(1, 1, 3); doCycle("rd3_after_reset"); idle();

    // Zero register: same-edge and next-edge reads
    setW0(1, 31, 64'hA0); setRd(0, 1, 31); setRd(1, 1, 31); doCycle("zero_same"); idle();
    setRd(0, 1, 31); setRd(1, 1, 31); doCycle("zero_next"); idle();

    // Pattern fill, alternating write ports, then staggered readback
    for (int i = 0; i < 31; i++) begin
      if (i % 2 == 0) setW0(1, i, DW'(i) * 64'h0000010204080001);
      else            setW1(1, i, DW'(i) * 64'h0000010204080001);
      doCycle($sformatf("fill%0d", i)); idle();
    end
    for (int i = 1; i < 31; i++) begin
      setRd(0, 1, i - 1); setRd(1, 1, i);
      doCycle($sformatf("readback%0d", i)); idle();
    end

    // Write collision
    setW0(1, 7, 64'h11); setW1(1, 7, 64'h22); setRd(0, 1, 7); doCycle("collide_same"); idle();
    setRd(0, 1, 7); setRd(1, 1, 7); doCycle("collide_next"); idle();

    // Bypass modes
    setW1(1, 5, 64'h55); doCycle("wr5_55"); idle();
    setW0(1, 5, 64'h66); setRd(1, 1, 5); doCycle("bypass_same"); idle();
    setRd(1, 1, 5); doCycle("bypass_next"); idle();

    // Read hold while enable is low
    setW0(1, 2, 64'h2); doCycle("wr2"); idle();
    setRd(0, 1, 2); doCycle("rd2"); idle();
    setW0(1, 2, 64'h99); setRd(0, 0, 2); doCycle("hold_wr"); idle();
    setRd(0, 0, 2); doCycle("hold"); idle();
    setRd(0, 1, 2); doCycle("hold_release"); idle();

    // Randomized traffic; narrow address range half the time to force hits
    for (int n = 0; n < 400; n++) begin
      int span;
      span = ($urandom_range(0, 1) == 1) ? 3 : 31;
      for (int p = 0; p < NR; p++) setRd(p, 1'($urandom_range(0, 1)), 28 + $urandom_range(0, span) - (span == 3 ? 0 : 28));
      setW0(1'($urandom_range(0, 1)), 28 + $urandom_range(0, span) - (span == 3 ? 0 : 28), {$urandom, $urandom});
      setW1(1'($urandom_range(0, 1)), 28 + $urandom_range(0, span) - (span == 3 ? 0 : 28), {$urandom, $urandom});
      doCycle($sformatf("rand%0d", n));
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
